// File: rtl/fp_norm_sequencer.sv
// Multi-cycle normalise/pack stage for single-precision FP results.
// Takes a raw sign/exponent/25-bit mantissa (with carry), normalises it using one
// shared leading-zero counter, and emits a packed IEEE-754 word plus flags.

// Leading-zero counter over a MANT_W-bit mantissa; an all-zero input returns MANT_W.
module leading_zeros #(
  parameter int W  = 24,
  parameter int ZW = 5
) (
  input  logic [W-1:0]  x,
  output logic [ZW-1:0] zero
);
  // Scan from LSB upward so the highest set bit wins.
  always_comb begin
    zero = ZW'(W);
    for (int i = 0; i < W; i++) begin
      if (x[i]) zero = ZW'(W - 1 - i);
    end
  end
endmodule

module fp_norm_sequencer #(
  parameter int MANT_W       = 24,
  parameter int EXP_W        = 8,
  parameter bit FLUSH_DENORM = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [EXP_W-1:0]        in_exp,
  input  logic [MANT_W:0]         in_mant,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W-1:0] out_data,
  output logic [2:0]              out_flags
);
  localparam int FRAC_W = MANT_W - 1;
  localparam int WORD_W = EXP_W + MANT_W;
  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_SHIFT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [WORD_W-1:0]   out_data_q, out_data_d;
  logic [2:0]          out_flags_q, out_flags_d;
  logic                sign_q, sign_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic [MANT_W:0]     mant_q, mant_d;
  logic [4:0]          lz_q, lz_d;

  logic [4:0]          lz_w;
  logic [EXP_W:0]      exp_inc;
  logic [FRAC_W-1:0]   frac_lz;
  logic [FRAC_W-1:0]   frac_dn;
  logic [4:0]          dn_amt;

  function automatic logic [WORD_W-1:0] pack(input logic s, input logic [EXP_W-1:0] e,
                                             input logic [FRAC_W-1:0] f);
    return {s, e, f};
  endfunction

  leading_zeros #(.W(MANT_W), .ZW(5)) u_lz (
    .x    (mant_q[MANT_W-1:0]),
    .zero (lz_w)
  );

  // Exponent increment is one bit wider so the carry-into-infinity case is visible.
  // The hidden-bit position falls off the top when shifting, so shifts work on the fraction only.
  always_comb begin
    exp_inc = {1'b0, exp_q} + {{EXP_W{1'b0}}, 1'b1};
    frac_lz = mant_q[FRAC_W-1:0] << lz_q;
    dn_amt  = exp_q[4:0] - 5'd1;
    frac_dn = mant_q[FRAC_W-1:0] << dn_amt;
  end

  // Next-state and datapath: classify in CHECK, normalise in SHIFT, hold result in DONE.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_flags_d = out_flags_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    mant_d      = mant_q;
    lz_d        = lz_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          sign_d  = in_sign;
          exp_d   = in_exp;
          mant_d  = in_mant;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        state_d     = S_DONE;
        out_valid_d = 1'b1;
        out_flags_d = 3'b000;
        if (exp_q == EXP_MAX) begin
          out_data_d = pack(sign_q, EXP_MAX, mant_q[FRAC_W-1:0]);
        end else if (mant_q == '0) begin
          out_data_d  = pack(sign_q, '0, '0);
          out_flags_d = 3'b001;
        end else if (mant_q[MANT_W]) begin
          if (exp_inc == {1'b0, EXP_MAX}) begin
            out_data_d  = pack(sign_q, EXP_MAX, '0);
            out_flags_d = 3'b100;
          end else begin
            out_data_d = pack(sign_q, exp_inc[EXP_W-1:0], mant_q[MANT_W-1:1]);
          end
        end else if (exp_q == '0) begin
          out_data_d = pack(sign_q, '0, mant_q[FRAC_W-1:0]);
        end else begin
          lz_d        = lz_w;
          state_d     = S_SHIFT;
          out_valid_d = 1'b0;
        end
      end
      S_SHIFT: begin
        state_d     = S_DONE;
        out_valid_d = 1'b1;
        if (EXP_W'(lz_q) < exp_q) begin
          out_data_d  = pack(sign_q, exp_q - EXP_W'(lz_q), frac_lz);
          out_flags_d = 3'b000;
        end else if (FLUSH_DENORM) begin
          out_data_d  = pack(sign_q, '0, '0);
          out_flags_d = 3'b011;
        end else begin
          out_data_d  = pack(sign_q, '0, frac_dn);
          out_flags_d = 3'b010;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE);
  end

  // All state and result registers; reset clears everything and drops any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_flags_q <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      lz_q        <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_flags_q <= out_flags_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      lz_q        <= lz_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_flags = out_flags_q;
endmodule

// File: tb/tb_fp_norm_sequencer.sv
// Directed bench for fp_norm_sequencer: one flushing and one denormal-producing instance
// share all inputs; expected words are hand-packed IEEE-754 values.
module tb_fp_norm_sequencer;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic        out_ready;
  logic        in_ready, in_ready_nf;
  logic        out_valid, out_valid_nf;
  logic [31:0] out_data, out_data_nf;
  logic [2:0]  out_flags, out_flags_nf;

  int n_chk = 0;
  int n_err = 0;

  fp_norm_sequencer #(.FLUSH_DENORM(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags)
  );

  fp_norm_sequencer #(.FLUSH_DENORM(1'b0)) dut_nf (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_nf),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid_nf), .out_ready(out_ready), .out_data(out_data_nf),
    .out_flags(out_flags_nf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Issue one operation and wait for the result; accept edge counts as cycle 1.
  task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                        input logic [24:0] m, input int lat,
                        input logic [31:0] d, input logic [2:0] f,
                        input logic [31:0] d_nf, input logic [2:0] f_nf);
    int cnt;
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    in_sign = s; in_exp = e; in_mant = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 8) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, "_lat"}, cnt, lat);
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_flags"}, {29'd0, out_flags}, {29'd0, f});
    chk({tag, "_nf_vld"}, {31'd0, out_valid_nf}, 32'd1);
    chk({tag, "_nf_data"}, out_data_nf, d_nf);
    chk({tag, "_nf_flags"}, {29'd0, out_flags_nf}, {29'd0, f_nf});
  endtask

  task automatic pop(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_pop_vld"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_rdy", {31'd0, in_ready}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_flags", {29'd0, out_flags}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_rdy", {31'd0, in_ready}, 32'd1);

    // Left normalise by 4: 0x0F28D5 -> 0xF28D50, exp 130-4=126.
    run_op("lz4", 1'b0, 8'd130, 25'h00F28D5, 3, 32'h3F728D50, 3'b000, 32'h3F728D50, 3'b000);
    pop("lz4");
    // Carry out: right shift, exp+1.
    run_op("carry", 1'b0, 8'd100, 25'h1800000, 2, 32'h32C00000, 3'b000, 32'h32C00000, 3'b000);
    pop("carry");
    // Carry into exponent 255 -> signed infinity.
    run_op("ovf", 1'b1, 8'd254, 25'h1800000, 2, 32'hFF800000, 3'b100, 32'hFF800000, 3'b100);
    pop("ovf");
    // Zero mantissa.
    run_op("zero", 1'b1, 8'd77, 25'h0000000, 2, 32'h80000000, 3'b001, 32'h80000000, 3'b001);
    pop("zero");
    // Exponent 255 passes through, carry bit ignored.
    run_op("inf", 1'b0, 8'd255, 25'h1123456, 2, 32'h7F923456, 3'b000, 32'h7F923456, 3'b000);
    pop("inf");
    // Denormal input passes unchanged.
    run_op("den", 1'b1, 8'd0, 25'h0000ABC, 2, 32'h80000ABC, 3'b000, 32'h80000ABC, 3'b000);
    pop("den");
    // Already normalised still takes the shift path.
    run_op("norm", 1'b0, 8'd127, 25'h0800000, 3, 32'h3F800000, 3'b000, 32'h3F800000, 3'b000);
    pop("norm");
    // lz=19 >= exp=3: flush vs denormal (mant<<2).
    run_op("unf", 1'b0, 8'd3, 25'h0000010, 3, 32'h00000000, 3'b011, 32'h00000040, 3'b010);
    pop("unf");
    // lz=4 < exp=5: lands on exponent 1.
    run_op("lzlt", 1'b0, 8'd5, 25'h0080000, 3, 32'h00800000, 3'b000, 32'h00800000, 3'b000);
    pop("lzlt");
    // lz=4 == exp=4: underflow; denormal result is mant<<3.
    run_op("lzeq", 1'b0, 8'd4, 25'h0080000, 3, 32'h00000000, 3'b011, 32'h00400000, 3'b010);
    pop("lzeq");

    // Backpressure: result held, new input ignored.
    run_op("hold", 1'b0, 8'd100, 25'h1800000, 2, 32'h32C00000, 3'b000, 32'h32C00000, 3'b000);
    in_valid = 1'b1; in_sign = 1'b1; in_exp = 8'd10; in_mant = 25'h0000001;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_vld", {31'd0, out_valid}, 32'd1);
      chk("hold_data", out_data, 32'h32C00000);
      chk("hold_rdy", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    pop("hold");
    repeat (4) begin
      @(posedge clk); #1;
      chk("hold_noop", {31'd0, out_valid}, 32'd0);
    end

    // Reset while in SHIFT.
    in_sign = 1'b0; in_exp = 8'd130; in_mant = 25'h00F28D5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst6_vld", {31'd0, out_valid}, 32'd0);
    chk("rst6_rdy", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst6_rel_rdy", {31'd0, in_ready}, 32'd1);
    chk("rst6_data", out_data, 32'd0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("rst6_stale", {31'd0, out_valid}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
